// File: rtl/load_pkg.sv
// Shared types for the load data register stage: load opcodes, fault codes,
// FSM states and the alignment check used at request time.
package load_pkg;

    localparam int XLEN = 64;

    typedef enum logic [2:0] {
        LOAD_LB      = 3'b000,
        LOAD_LH      = 3'b001,
        LOAD_LW      = 3'b010,
        LOAD_LD      = 3'b011,
        LOAD_LBU     = 3'b100,
        LOAD_LHU     = 3'b101,
        LOAD_LWU     = 3'b110,
        LOAD_ILLEGAL = 3'b111
    } load_op_t;

    typedef enum logic [1:0] {
        FAULT_NONE       = 2'b00,
        FAULT_MISALIGNED = 2'b01,
        FAULT_ILLEGAL    = 2'b10,
        FAULT_TIMEOUT    = 2'b11
    } fault_code_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_DONE = 2'b10
    } lstate_t;

    // Natural alignment: the access size must divide the byte offset.
    function automatic logic is_misaligned(input load_op_t op, input logic [2:0] off);
        logic bad;
        bad = 1'b0;
        case (op)
            LOAD_LH, LOAD_LHU: bad = off[0];
            LOAD_LW, LOAD_LWU: bad = (off[1:0] != 2'b00);
            LOAD_LD:           bad = (off != 3'b000);
            default:           bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Byte-lane extraction and sign/zero extension of a doubleword-aligned read.
module load_extend
    import load_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      byte_off,
    input  load_op_t        op,
    output logic [XLEN-1:0] ext
);

    logic [XLEN-1:0] shifted;

    assign shifted = rdata >> {byte_off, 3'b000};

    always_comb begin
        ext = shifted;
        case (op)
            LOAD_LB:  ext = {{56{shifted[7]}},  shifted[7:0]};
            LOAD_LH:  ext = {{48{shifted[15]}}, shifted[15:0]};
            LOAD_LW:  ext = {{32{shifted[31]}}, shifted[31:0]};
            LOAD_LBU: ext = {56'd0, shifted[7:0]};
            LOAD_LHU: ext = {48'd0, shifted[15:0]};
            LOAD_LWU: ext = {32'd0, shifted[31:0]};
            default:  ext = shifted;
        endcase
    end

endmodule

// File: rtl/load_data_reg.sv
// Memory data register stage: waits for the data memory, captures the extended
// load result and reports misaligned, illegal and timeout faults.
module load_data_reg
    import load_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic [2:0]        funct3,
    input  logic [2:0]        byte_off,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] mem_data_reg,
    output logic              load_done,
    output logic              busy,
    output logic              load_fault,
    output logic [1:0]        fault_code
);

    localparam logic [7:0] COUNT_LAST = 8'(WAIT_MAX - 1);

    lstate_t         state, state_n;
    load_op_t        op_q, op_n;
    logic [2:0]      off_q, off_n;
    logic [7:0]      count, count_n;
    logic [DATA_W-1:0] data_n;
    logic [DATA_W-1:0] ext_value;
    fault_code_t     fault_q, fault_n;

    load_extend u_extend (
        .rdata    (mem_rdata),
        .byte_off (off_q),
        .op       (op_q),
        .ext      (ext_value)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            op_q         <= LOAD_LB;
            off_q        <= 3'b000;
            count        <= 8'd0;
            mem_data_reg <= '0;
            fault_q      <= FAULT_NONE;
        end else begin
            state        <= state_n;
            op_q         <= op_n;
            off_q        <= off_n;
            count        <= count_n;
            mem_data_reg <= data_n;
            fault_q      <= fault_n;
        end
    end

    // DONE accepts a new request exactly like IDLE so loads can run back to back.
    always_comb begin
        state_n = state;
        op_n    = op_q;
        off_n   = off_q;
        count_n = count;
        data_n  = mem_data_reg;
        fault_n = fault_q;
        case (state)
            S_IDLE, S_DONE: begin
                if (load_req) begin
                    op_n    = load_op_t'(funct3);
                    off_n   = byte_off;
                    count_n = 8'd0;
                    if (funct3 == 3'b111) begin
                        fault_n = FAULT_ILLEGAL;
                        state_n = S_DONE;
                    end else if (is_misaligned(load_op_t'(funct3), byte_off)) begin
                        fault_n = FAULT_MISALIGNED;
                        state_n = S_DONE;
                    end else begin
                        fault_n = FAULT_NONE;
                        state_n = S_WAIT;
                    end
                end else if (state == S_DONE) begin
                    state_n = S_IDLE;
                end
            end
            S_WAIT: begin
                if (mem_ready) begin
                    data_n  = ext_value;
                    state_n = S_DONE;
                end else if (count == COUNT_LAST) begin
                    fault_n = FAULT_TIMEOUT;
                    state_n = S_DONE;
                end else begin
                    count_n = count + 8'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign busy       = (state == S_WAIT);
    assign load_done  = (state == S_DONE);
    assign load_fault = load_done && (fault_q != FAULT_NONE);
    assign fault_code = fault_q;

endmodule

// File: tb/tb_load_data_reg.sv
// Directed self-checking bench for load_data_reg with hand-computed results.
module tb_load_data_reg;

    logic        clk;
    logic        reset;
    logic        load_req;
    logic [2:0]  funct3;
    logic [2:0]  byte_off;
    logic [63:0] mem_rdata;
    logic        mem_ready;
    logic [63:0] mem_data_reg;
    logic        load_done;
    logic        busy;
    logic        load_fault;
    logic [1:0]  fault_code;

    int assertCount = 0;
    int failCount   = 0;

    load_data_reg #(.DATA_W(64), .WAIT_MAX(15)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_req     (load_req),
        .funct3       (funct3),
        .byte_off     (byte_off),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .mem_data_reg (mem_data_reg),
        .load_done    (load_done),
        .busy         (busy),
        .load_fault   (load_fault),
        .fault_code   (fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and run until load_done; readyAt is the WAIT cycle index
    // that sees mem_ready (-1 for never). Returns busy cycles and edges to done.
    task automatic applyStimulus(input logic [2:0] f3, input logic [2:0] off,
                                 input logic [63:0] rdata, input int readyAt,
                                 output int busyCycles, output int latency);
        int cycle;
        load_req  = 1'b1;
        funct3    = f3;
        byte_off  = off;
        mem_ready = 1'b0;
        mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        step();
        load_req   = 1'b0;
        funct3     = 3'b000;
        byte_off   = 3'b000;
        latency    = 1;
        busyCycles = 0;
        cycle      = 0;
        while (!load_done && latency < 40) begin
            if (busy) busyCycles++;
            mem_ready = (cycle == readyAt);
            mem_rdata = mem_ready ? rdata : 64'hDEAD_BEEF_DEAD_BEEF;
            step();
            latency++;
            cycle++;
        end
        mem_ready = 1'b0;
        mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    endtask

    int bc, lat, doneSeen;

    initial begin
        reset     = 1'b1;
        load_req  = 1'b0;
        funct3    = 3'b000;
        byte_off  = 3'b000;
        mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        mem_ready = 1'b0;
        #12;
        checkOutput("reset_data",  mem_data_reg, 64'd0);
        checkOutput("reset_done",  load_done, 0);
        checkOutput("reset_busy",  busy, 0);
        checkOutput("reset_fault", load_fault, 0);
        checkOutput("reset_code",  fault_code, 0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // LB off3, zero-wait, sign extension of 0x80
        applyStimulus(3'b000, 3'd3, 64'h0000_0000_8000_0000, 0, bc, lat);
        checkOutput("lb_data",    mem_data_reg, 64'hFFFF_FFFF_FFFF_FF80);
        checkOutput("lb_latency", lat, 2);
        checkOutput("lb_busy",    bc, 1);
        checkOutput("lb_done",    load_done, 1);
        checkOutput("lb_fault",   load_fault, 0);
        checkOutput("lb_code",    fault_code, 0);
        step();
        checkOutput("lb_done_pulse", load_done, 0);

        // LWU off4, ready in fourth WAIT cycle
        applyStimulus(3'b110, 3'd4, 64'h89AB_CDEF_0123_4567, 3, bc, lat);
        checkOutput("lwu_data",    mem_data_reg, 64'h0000_0000_89AB_CDEF);
        checkOutput("lwu_busy",    bc, 4);
        checkOutput("lwu_latency", lat, 5);
        step();

        // LH off1: misaligned
        applyStimulus(3'b001, 3'd1, 64'h1111_2222_3333_4444, 0, bc, lat);
        checkOutput("lh_mis_latency", lat, 1);
        checkOutput("lh_mis_fault",   load_fault, 1);
        checkOutput("lh_mis_code",    fault_code, 2'b01);
        checkOutput("lh_mis_data",    mem_data_reg, 64'h0000_0000_89AB_CDEF);
        checkOutput("lh_mis_busy",    bc, 0);
        step();
        checkOutput("code_held_idle", fault_code, 2'b01);
        checkOutput("fault_pulse",    load_fault, 0);

        // funct3=111 off1: illegal takes priority over misaligned
        applyStimulus(3'b111, 3'd1, 64'h0, 0, bc, lat);
        checkOutput("ill_latency", lat, 1);
        checkOutput("ill_code",    fault_code, 2'b10);
        checkOutput("ill_fault",   load_fault, 1);
        step();

        // LD off4: misaligned doubleword
        applyStimulus(3'b011, 3'd4, 64'h0, 0, bc, lat);
        checkOutput("ld_mis_code", fault_code, 2'b01);
        step();

        // Timeout: ready never arrives
        applyStimulus(3'b011, 3'd0, 64'h5555_5555_5555_5555, -1, bc, lat);
        checkOutput("to_busy",    bc, 15);
        checkOutput("to_latency", lat, 16);
        checkOutput("to_code",    fault_code, 2'b11);
        checkOutput("to_fault",   load_fault, 1);
        checkOutput("to_data",    mem_data_reg, 64'h0000_0000_89AB_CDEF);
        step();

        // Ready in the 15th WAIT cycle wins over the timeout
        applyStimulus(3'b101, 3'd6, 64'hFEDC_0000_0000_0000, 14, bc, lat);
        checkOutput("late_busy",  bc, 15);
        checkOutput("late_code",  fault_code, 2'b00);
        checkOutput("late_fault", load_fault, 0);
        checkOutput("late_data",  mem_data_reg, 64'h0000_0000_0000_FEDC);
        step();

        // LD then LBU requested during the DONE cycle
        applyStimulus(3'b011, 3'd0, 64'h0123_4567_89AB_CDEF, 0, bc, lat);
        checkOutput("ld_data", mem_data_reg, 64'h0123_4567_89AB_CDEF);
        applyStimulus(3'b100, 3'd7, 64'hF0AA_BBCC_DDEE_FF11, 0, bc, lat);
        checkOutput("b2b_latency", lat, 2);
        checkOutput("b2b_busy",    bc, 1);
        checkOutput("b2b_data",    mem_data_reg, 64'h0000_0000_0000_00F0);
        step();

        // Reset pulsed mid-WAIT
        load_req = 1'b1;
        funct3   = 3'b011;
        byte_off = 3'd0;
        step();
        load_req = 1'b0;
        step();
        checkOutput("mid_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_data", mem_data_reg, 64'd0);
        checkOutput("rst_done", load_done, 0);
        checkOutput("rst_code", fault_code, 0);
        #1 reset = 1'b0;
        doneSeen = 0;
        for (int i = 0; i < 20; i++) begin
            mem_ready = (i == 3);
            mem_rdata = 64'h7777_7777_7777_7777;
            step();
            if (load_done) doneSeen++;
        end
        mem_ready = 1'b0;
        checkOutput("rst_no_done", doneSeen, 0);
        checkOutput("rst_data_kept", mem_data_reg, 64'd0);

        applyStimulus(3'b011, 3'd0, 64'hCAFE_F00D_1234_5678, 1, bc, lat);
        checkOutput("post_rst_data",    mem_data_reg, 64'hCAFE_F00D_1234_5678);
        checkOutput("post_rst_latency", lat, 3);
        checkOutput("post_rst_code",    fault_code, 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
